instruction_fetch: RTL and testbench

- Producer side of the decoder's instruction interface. Owns the program counter and issues one-outstanding-request reads to instruction memory.
- Delivers each fetched word as registered `instr_data` with a one-cycle `instr_en` strobe, which the decoder latches on the same posedge.
- Handles decode-side stall, PC redirect (branch/jump) with stale-response draining, and misaligned-target faulting.

---
 rtl/instruction_fetch_if.sv | 31 +++
 rtl/instruction_fetch.sv | 112 +++++++++++
 tb/tb_instruction_fetch.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
//------------------------------------------------------------------------------
// instruction_fetch_if : imem read channel plus decoder-side delivery bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_data;
  logic        instr_en;
  logic [31:0] instr_pc;
  logic        misaligned_fault;

  modport master (
    output imem_req, imem_addr, instr_data, instr_en, instr_pc, misaligned_fault,
    input  imem_ready, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_data, instr_en, instr_pc, misaligned_fault,
    output imem_ready, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch.sv
//------------------------------------------------------------------------------
// instruction_fetch : PC owner, single-outstanding imem reader, decoder feeder
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic           clk,
  input  wire logic           rst,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] drain_addr_q;
  logic [31:0] hold_data_q;
  logic [31:0] hold_pc_q;
  logic [31:0] instr_data_q;
  logic [31:0] instr_pc_q;
  logic        instr_en_q;
  logic        fault_q;
  logic        redirect_misaligned;

  assign redirect_misaligned = (bus.redirect_pc[1:0] != 2'b00);

  // Request is combinational on state so it drops in the same cycle rst rises.
  assign bus.imem_req  = !rst && ((state_q == FETCH) || (state_q == DRAIN));
  assign bus.imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

  assign bus.instr_data       = instr_data_q;
  assign bus.instr_pc         = instr_pc_q;
  assign bus.instr_en         = instr_en_q;
  assign bus.misaligned_fault = fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      hold_data_q  <= 32'h0;
      hold_pc_q    <= RESET_PC;
      instr_data_q <= 32'h0;
      instr_pc_q   <= RESET_PC;
      instr_en_q   <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      instr_en_q <= 1'b0;
      if (state_q != HALT && bus.redirect) begin
        if (redirect_misaligned) begin
          fault_q <= 1'b1;
          state_q <= HALT;
        end else begin
          pc_q <= bus.redirect_pc;
          case (state_q)
            FETCH: begin
              // An unanswered request must still be completed before refetching.
              if (!bus.imem_ready) begin
                drain_addr_q <= pc_q;
                state_q      <= DRAIN;
              end
            end
            HOLD:    state_q <= FETCH;
            default: state_q <= state_q;
          endcase
        end
      end else begin
        case (state_q)
          FETCH: begin
            if (bus.imem_ready) begin
              pc_q <= pc_q + 32'd4;
              if (bus.stall) begin
                hold_data_q <= bus.imem_rdata;
                hold_pc_q   <= pc_q;
                state_q     <= HOLD;
              end else begin
                instr_data_q <= bus.imem_rdata;
                instr_pc_q   <= pc_q;
                instr_en_q   <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (!bus.stall) begin
              instr_data_q <= hold_data_q;
              instr_pc_q   <= hold_pc_q;
              instr_en_q   <= 1'b1;
              state_q      <= FETCH;
            end
          end
          DRAIN: begin
            if (bus.imem_ready) begin
              state_q <= FETCH;
            end
          end
          default: state_q <= HALT;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
//------------------------------------------------------------------------------
// tb_instruction_fetch : directed scenarios plus randomized model comparison
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instruction_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: fetch address, pending-discard request, one-word buffer.
  logic        m_halt, m_fault, m_stale, m_buf_v, m_en;
  logic [31:0] m_pc, m_stale_addr, m_buf_d, m_buf_pc, m_data, m_ipc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_ready  = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic model_step(input logic rs, input logic rdy, input logic [31:0] rd,
                            input logic st, input logic rdr, input logic [31:0] rp);
    if (rs) begin
      m_halt = 0; m_fault = 0; m_stale = 0; m_buf_v = 0; m_en = 0;
      m_pc = RST_PC; m_data = 0; m_ipc = RST_PC;
      return;
    end
    m_en = 0;
    if (m_halt) return;
    if (rdr) begin
      if (rp[1:0] != 2'b00) begin
        m_halt = 1; m_fault = 1;
      end else begin
        if (!m_buf_v && !m_stale && !rdy) begin
          m_stale = 1; m_stale_addr = m_pc;
        end
        m_buf_v = 0;
        m_pc = rp;
      end
    end else if (m_buf_v) begin
      if (!st) begin
        m_buf_v = 0; m_en = 1; m_data = m_buf_d; m_ipc = m_buf_pc;
      end
    end else if (rdy) begin
      if (m_stale) begin
        m_stale = 0;
      end else begin
        if (st) begin
          m_buf_v = 1; m_buf_d = rd; m_buf_pc = m_pc;
        end else begin
          m_en = 1; m_data = rd; m_ipc = m_pc;
        end
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", bus.imem_req); else n_pass++;
    n_checks++; if (bus.instr_en !== 1'b0) $display("FAIL rst_en got %b exp 0", bus.instr_en); else n_pass++;
    n_checks++; if (bus.instr_data !== 32'h0) $display("FAIL rst_data got %h exp 0", bus.instr_data); else n_pass++;
    n_checks++; if (bus.instr_pc !== RST_PC) $display("FAIL rst_pc got %h exp %h", bus.instr_pc, RST_PC); else n_pass++;
    n_checks++; if (bus.misaligned_fault !== 1'b0) $display("FAIL rst_fault got %b exp 0", bus.misaligned_fault); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC)
      $display("FAIL rst_release got req=%b addr=%h exp req=1 addr=%h", bus.imem_req, bus.imem_addr, RST_PC); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    words[0] = 32'h0000_0013; words[1] = 32'h0010_0093; words[2] = 32'h0020_0113;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.imem_addr !== 32'(i * 4)) $display("FAIL b2b_addr%0d got %h exp %h", i, bus.imem_addr, i * 4); else n_pass++;
      bus.imem_ready = 1'b1;
      bus.imem_rdata = words[i];
      tick();
      n_checks++; if (bus.instr_en !== 1'b1 || bus.instr_data !== words[i] || bus.instr_pc !== 32'(i * 4))
        $display("FAIL b2b_out%0d got en=%b d=%h pc=%h exp en=1 d=%h pc=%h", i, bus.instr_en, bus.instr_data, bus.instr_pc, words[i], i * 4);
      else n_pass++;
    end
    n_checks++; if (bus.imem_addr !== 32'hC) $display("FAIL b2b_addr3 got %h exp c", bus.imem_addr); else n_pass++;
    bus.imem_ready = 1'b0;
    tick();
    n_checks++; if (bus.instr_en !== 1'b0 || bus.instr_data !== words[2])
      $display("FAIL b2b_hold got en=%b d=%h exp en=0 d=%h", bus.instr_en, bus.instr_data, words[2]); else n_pass++;
  endtask

  task automatic test_latency();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 2; w++) begin
        bus.imem_ready = 1'b0;
        tick();
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(i * 4) || bus.instr_en !== 1'b0)
          $display("FAIL lat_wait%0d_%0d got req=%b addr=%h en=%b exp req=1 addr=%h en=0", i, w, bus.imem_req, bus.imem_addr, bus.instr_en, i * 4);
        else n_pass++;
      end
      bus.imem_ready = 1'b1;
      bus.imem_rdata = 32'hA000_0000 + 32'(i);
      tick();
      bus.imem_ready = 1'b0;
      n_checks++; if (bus.instr_en !== 1'b1 || bus.instr_pc !== 32'(i * 4) || bus.instr_data !== 32'hA000_0000 + 32'(i))
        $display("FAIL lat_done%0d got en=%b pc=%h d=%h exp en=1 pc=%h", i, bus.instr_en, bus.instr_pc, bus.instr_data, i * 4);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h1234_5678;
    tick();
    bus.imem_rdata = 32'hDEAD_BEEF; bus.stall = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.instr_en !== 1'b0 || bus.imem_req !== 1'b0)
        $display("FAIL stall_hold%0d got en=%b req=%b exp en=0 req=0", i, bus.instr_en, bus.imem_req); else n_pass++;
      if (i < 2) tick();
    end
    bus.stall = 1'b0;
    tick();
    n_checks++; if (bus.instr_en !== 1'b1 || bus.instr_data !== 32'hDEAD_BEEF || bus.instr_pc !== 32'h4)
      $display("FAIL stall_release got en=%b d=%h pc=%h exp en=1 d=deadbeef pc=4", bus.instr_en, bus.instr_data, bus.instr_pc);
    else n_pass++;
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8)
      $display("FAIL stall_next got req=%b addr=%h exp req=1 addr=8", bus.imem_req, bus.imem_addr); else n_pass++;
  endtask

  task automatic test_redirect_outstanding();
    do_reset();
    bus.imem_ready = 1'b1;
    tick(); tick();
    bus.imem_ready = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8)
      $display("FAIL redir_out_hold0 got req=%b addr=%h exp req=1 addr=8", bus.imem_req, bus.imem_addr); else n_pass++;
    tick();
    n_checks++; if (bus.imem_addr !== 32'h8) $display("FAIL redir_out_hold1 got %h exp 8", bus.imem_addr); else n_pass++;
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h1111_1111;
    tick();
    bus.imem_ready = 1'b0;
    n_checks++; if (bus.instr_en !== 1'b0) $display("FAIL redir_out_stale got en=%b exp 0", bus.instr_en); else n_pass++;
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100)
      $display("FAIL redir_out_next got req=%b addr=%h exp req=1 addr=100", bus.imem_req, bus.imem_addr); else n_pass++;
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h2222_2222;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h40;
    tick();
    idle_inputs();
    n_checks++; if (bus.instr_en !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40)
      $display("FAIL redir_coin got en=%b req=%b addr=%h exp en=0 req=1 addr=40", bus.instr_en, bus.imem_req, bus.imem_addr);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC; bus.imem_ready = 1'b1;
    tick();
    bus.redirect = 1'b0; bus.imem_rdata = 32'h0BAD_CAFE;
    tick();
    bus.imem_ready = 1'b0;
    n_checks++; if (bus.instr_en !== 1'b1 || bus.instr_pc !== 32'hFFFF_FFFC || bus.imem_addr !== 32'h0 || bus.misaligned_fault !== 1'b0)
      $display("FAIL wrap got en=%b pc=%h addr=%h flt=%b exp en=1 pc=fffffffc addr=0 flt=0", bus.instr_en, bus.instr_pc, bus.imem_addr, bus.misaligned_fault);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    do_reset();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h102;
    tick();
    n_checks++; if (bus.misaligned_fault !== 1'b1) $display("FAIL mis_fault got %b exp 1", bus.misaligned_fault); else n_pass++;
    bus.redirect_pc = 32'h200; bus.imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.redirect = (i == 0);
      tick();
      n_checks++; if (bus.imem_req !== 1'b0 || bus.instr_en !== 1'b0 || bus.misaligned_fault !== 1'b1)
        $display("FAIL mis_halt%0d got req=%b en=%b flt=%b exp req=0 en=0 flt=1", i, bus.imem_req, bus.instr_en, bus.misaligned_fault);
      else n_pass++;
    end
    do_reset();
    n_checks++; if (bus.misaligned_fault !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC)
      $display("FAIL mis_clear got flt=%b req=%b addr=%h exp flt=0 req=1 addr=%h", bus.misaligned_fault, bus.imem_req, bus.imem_addr, RST_PC);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] rp;
    logic        rs;
    logic        exp_req;
    logic [31:0] exp_addr;
    int          errs;
    errs = 0;
    do_reset();
    model_step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 3000; c++) begin
      rs = ($urandom_range(0, 199) == 0) || (m_halt && $urandom_range(0, 15) == 0);
      rp = $urandom;
      if ($urandom_range(0, 4) != 0) rp[1:0] = 2'b00;
      rst             = rs;
      bus.imem_ready  = ($urandom_range(0, 1) == 1);
      bus.imem_rdata  = $urandom;
      bus.stall       = ($urandom_range(0, 2) == 0);
      bus.redirect    = ($urandom_range(0, 11) == 0);
      bus.redirect_pc = rp;
      model_step(rs, bus.imem_ready, bus.imem_rdata, bus.stall, bus.redirect, rp);
      tick();
      exp_req  = !rs && !m_halt && !m_buf_v;
      exp_addr = m_stale ? m_stale_addr : m_pc;
      n_checks++;
      if (bus.imem_req !== exp_req || (exp_req && bus.imem_addr !== exp_addr) ||
          bus.instr_en !== m_en || bus.instr_data !== m_data || bus.instr_pc !== m_ipc ||
          bus.misaligned_fault !== m_fault) begin
        if (errs < 10)
          $display("FAIL rand_cyc%0d got req=%b addr=%h en=%b d=%h pc=%h flt=%b exp req=%b addr=%h en=%b d=%h pc=%h flt=%b",
                   c, bus.imem_req, bus.imem_addr, bus.instr_en, bus.instr_data, bus.instr_pc, bus.misaligned_fault,
                   exp_req, exp_addr, m_en, m_data, m_ipc, m_fault);
        errs++;
      end else begin
        n_pass++;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_latency();
    test_stall();
    test_redirect_outstanding();
    test_redirect_coincident();
    test_wrap();
    test_misaligned();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
